serial_addsub: RTL and testbench

Parametrised bit-serial adder/subtractor, the sequential successor to the week-2 combinational adder.
- Latches two WIDTH-bit operands on a start pulse.
- Processes one bit per clock, LSB first, using a single full-adder cell and a carry flip-flop.
- Reports sum, carry-out and signed overflow with a done pulse.
- Used in later labs as a datapath unit driven by a controller FSM.

---
 rtl/serial_addsub.sv | 98 +++++++++
 tb/tb_serial_addsub.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flip-flop,
// LSB first, WIDTH+1 cycles from an accepted start to the done pulse.
module serial_addsub #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic bit_s;
  logic bit_c;

  assign bit_s = a_sh[0] ^ b_sh[0] ^ carry;
  assign bit_c = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);

  // Subtraction is a + ~b + 1, with the +1 injected as the initial carry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh   <= a;
            b_sh   <= mode ? ~b : b;
            carry  <= mode;
            cnt    <= '0;
            sum_sh <= '0;
            busy   <= 1'b1;
            state  <= SHIFT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        SHIFT: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= {bit_s, sum_sh[WIDTH-1:1]};
          carry  <= bit_c;
          cnt    <= cnt + CW'(1);
          // On the MSB step the old carry is the carry into the MSB.
          if (cnt == CW'(WIDTH - 1)) begin
            sum   <= {bit_s, sum_sh[WIDTH-1:1]};
            cout  <= bit_c;
            ovf   <= carry ^ bit_c;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub at WIDTH=4 and WIDTH=8 against an
// arithmetic reference model.
module tb_serial_addsub;

  logic       clk;
  logic       rst_n;

  logic       start4, mode4;
  logic [3:0] a4, b4;
  logic       busy4, done4, cout4, ovf4;
  logic [3:0] sum4;

  logic       start8, mode8;
  logic [7:0] a8, b8;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;

  int checks;
  int failures;
  int sel;

  logic       obs_busy, obs_done, obs_cout, obs_ovf;
  logic [7:0] obs_sum;

  serial_addsub #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .mode(mode4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  serial_addsub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    obs_busy = busy8;
    obs_done = done8;
    obs_cout = cout8;
    obs_ovf  = ovf8;
    obs_sum  = sum8;
    if (sel == 4) begin
      obs_busy = busy4;
      obs_done = done4;
      obs_cout = cout4;
      obs_ovf  = ovf4;
      obs_sum  = {4'b0000, sum4};
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: plain modular arithmetic plus the sign rule for overflow.
  function automatic logic [9:0] ref_calc(input int w, input bit m, input int av, input int bv);
    int mask, full, s;
    bit sa, sb, ss, co, ov;
    mask = (1 << w) - 1;
    full = av + (m ? ((~bv) & mask) : bv) + (m ? 1 : 0);
    s    = full & mask;
    co   = ((full >> w) & 1) != 0;
    sa   = ((av >> (w - 1)) & 1) != 0;
    sb   = ((bv >> (w - 1)) & 1) != 0;
    ss   = ((s >> (w - 1)) & 1) != 0;
    ov   = m ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
    return {ov, co, s[7:0]};
  endfunction

  task automatic set_inputs(input bit st, input bit m, input logic [7:0] av, input logic [7:0] bv);
    if (sel == 4) begin
      start4 = st;
      mode4  = m;
      a4     = av[3:0];
      b4     = bv[3:0];
    end else begin
      start8 = st;
      mode8  = m;
      a8     = av;
      b8     = bv;
    end
  endtask

  // One operation; with disturb set, start/mode/operands are scrambled while busy.
  task automatic applyStimulus(input bit m, input logic [7:0] av, input logic [7:0] bv, input bit disturb);
    logic [9:0] exp;
    int n;
    bit seen;
    exp = ref_calc(sel, m, 32'(av), 32'(bv));
    @(negedge clk);
    set_inputs(1'b1, m, av, bv);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 4 * sel) begin
      @(negedge clk);
      n++;
      if (disturb && n <= sel)
        set_inputs(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      else
        set_inputs(1'b0, m, av, bv);
      if (obs_done) seen = 1'b1;
      else checkOutput("busy", 32'(obs_busy), 32'(n <= sel));
    end
    checkOutput("latency", 32'(n), 32'(sel + 1));
    if (seen) begin
      checkOutput("sum", 32'(obs_sum), 32'(exp[7:0]));
      checkOutput("cout", 32'(obs_cout), 32'(exp[8]));
      checkOutput("ovf", 32'(obs_ovf), 32'(exp[9]));
      checkOutput("busy_at_done", 32'(obs_busy), 32'd0);
    end
    set_inputs(1'b0, m, av, bv);
    @(negedge clk);
    checkOutput("done_width", 32'(obs_done), 32'd0);
    checkOutput("sum_after", 32'(obs_sum), 32'(exp[7:0]));
  endtask

  logic [7:0] corners [5];
  int first, second;
  logic [7:0] s1, s2;
  logic c2;
  int dones;

  initial begin
    checks   = 0;
    failures = 0;
    sel      = 4;
    rst_n    = 1'b0;
    start4 = 0; mode4 = 0; a4 = 0; b4 = 0;
    start8 = 0; mode8 = 0; a8 = 0; b8 = 0;
    corners = '{8'd0, 8'd1, 8'd127, 8'd128, 8'd255};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rst_busy4", 32'(busy4), 32'd0);
    checkOutput("rst_done4", 32'(done4), 32'd0);
    checkOutput("rst_sum4",  32'(sum4),  32'd0);
    checkOutput("rst_cout4", 32'(cout4), 32'd0);
    checkOutput("rst_ovf4",  32'(ovf4),  32'd0);
    checkOutput("rst_busy8", 32'(busy8), 32'd0);
    checkOutput("rst_sum8",  32'(sum8),  32'd0);

    // Directed WIDTH=4 cases.
    applyStimulus(1'b0, 8'd5, 8'd3, 1'b0);
    applyStimulus(1'b0, 8'd15, 8'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("hold_sum", 32'(obs_sum), 32'd0);
      checkOutput("hold_cout", 32'(obs_cout), 32'd1);
    end
    applyStimulus(1'b1, 8'd3, 8'd5, 1'b0);
    applyStimulus(1'b1, 8'd7, 8'd8, 1'b0);

    // Back-to-back: start stays high across DONE.
    @(negedge clk);
    set_inputs(1'b1, 1'b0, 8'd2, 8'd2);
    first = 0; second = 0; s1 = 0; s2 = 0; c2 = 0;
    for (int i = 1; i <= 30 && second == 0; i++) begin
      @(negedge clk);
      if (i == 1) set_inputs(1'b1, 1'b1, 8'd9, 8'd4);
      if (obs_done) begin
        if (first == 0) begin
          first = i;
          s1 = obs_sum;
        end else begin
          second = i;
          s2 = obs_sum;
          c2 = obs_cout;
        end
      end
      if (first != 0 && i == first + 1) set_inputs(1'b0, 1'b1, 8'd9, 8'd4);
    end
    set_inputs(1'b0, 1'b0, 8'd0, 8'd0);
    checkOutput("b2b_first", 32'(first), 32'd5);
    checkOutput("b2b_gap", 32'(second - first), 32'd5);
    checkOutput("b2b_sum1", 32'(s1), 32'd4);
    checkOutput("b2b_sum2", 32'(s2), 32'd5);
    checkOutput("b2b_cout2", 32'(c2), 32'd1);
    @(negedge clk);

    // Disturbed operation, then reset in the middle of SHIFT.
    applyStimulus(1'b0, 8'd1, 8'd1, 1'b1);
    @(negedge clk);
    set_inputs(1'b1, 1'b0, 8'd1, 8'd1);
    @(negedge clk);
    set_inputs(1'b0, 1'b0, 8'd1, 8'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("mid_rst_busy", 32'(obs_busy), 32'd0);
    checkOutput("mid_rst_done", 32'(obs_done), 32'd0);
    checkOutput("mid_rst_sum",  32'(obs_sum),  32'd0);
    checkOutput("mid_rst_cout", 32'(obs_cout), 32'd0);
    checkOutput("mid_rst_ovf",  32'(obs_ovf),  32'd0);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (obs_done || obs_busy) dones++;
    end
    checkOutput("mid_rst_quiet", 32'(dones), 32'd0);
    applyStimulus(1'b0, 8'd6, 8'd7, 1'b0);

    // WIDTH=8: boundary operand pairs, then random operations.
    sel = 8;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        for (int m = 0; m < 2; m++)
          applyStimulus(1'(m), corners[i], corners[j], 1'b0);
    for (int i = 0; i < 300; i++)
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                    8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
